// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC register, instruction-memory address drive and IF/ID register.
// Handles stall, redirect, flush and sticky fetch-fault detection.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned INSTR_WORDS = 128
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [31:0] IM_Address,
    input  logic [31:0] IM_Instruction,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] ID_Instruction,
    output logic [31:0] ID_PCPlus4,
    output logic        ID_Valid,
    output logic        Fault,
    output logic [31:0] FaultPC,
    output logic [31:0] FetchCount
);

    // state    | meaning
    // ST_RUN   | fetching; PC follows redirect/stall/sequential rules
    // ST_FAULT | bad PC seen; PC, FaultPC, FetchCount frozen, IF/ID bubble until Rst
    typedef enum logic {ST_RUN, ST_FAULT} state_t;

    localparam logic [32:0] PC_LIMIT = 33'(INSTR_WORDS) * 33'd4;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pcp4;
    logic        r_id_valid;
    logic [31:0] r_fault_pc;
    logic [31:0] r_fetch_count;

    state_t      w_nxt_state;
    logic [31:0] w_nxt_pc;
    logic [31:0] w_nxt_id_instr;
    logic [31:0] w_nxt_id_pcp4;
    logic        w_nxt_id_valid;
    logic [31:0] w_nxt_fault_pc;
    logic [31:0] w_nxt_fetch_count;
    logic [31:0] w_pc_plus4;
    logic        w_pc_bad;

    assign w_pc_plus4 = r_pc + 32'd4;
    // Widened compare so the limit never wraps for large memories
    assign w_pc_bad   = (r_pc[1:0] != 2'b00) || ({1'b0, r_pc} >= PC_LIMIT);

    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_pc          = r_pc;
        w_nxt_id_instr    = r_id_instr;
        w_nxt_id_pcp4     = r_id_pcp4;
        w_nxt_id_valid    = r_id_valid;
        w_nxt_fault_pc    = r_fault_pc;
        w_nxt_fetch_count = r_fetch_count;
        case (r_state)
            ST_RUN: begin
                if (w_pc_bad) begin
                    w_nxt_state    = ST_FAULT;
                    w_nxt_fault_pc = r_pc;
                    w_nxt_id_instr = 32'd0;
                    w_nxt_id_pcp4  = 32'd0;
                    w_nxt_id_valid = 1'b0;
                end else if (Redirect) begin
                    w_nxt_pc       = RedirectTarget;
                    w_nxt_id_instr = 32'd0;
                    w_nxt_id_pcp4  = 32'd0;
                    w_nxt_id_valid = 1'b0;
                end else begin
                    if (!Stall) begin
                        w_nxt_pc = w_pc_plus4;
                    end
                    if (Flush) begin
                        w_nxt_id_instr = 32'd0;
                        w_nxt_id_pcp4  = 32'd0;
                        w_nxt_id_valid = 1'b0;
                    end else if (!Stall) begin
                        w_nxt_id_instr    = IM_Instruction;
                        w_nxt_id_pcp4     = w_pc_plus4;
                        w_nxt_id_valid    = 1'b1;
                        w_nxt_fetch_count = r_fetch_count + 32'd1;
                    end
                end
            end
            ST_FAULT: begin
                w_nxt_id_instr = 32'd0;
                w_nxt_id_pcp4  = 32'd0;
                w_nxt_id_valid = 1'b0;
            end
            default: begin
                w_nxt_state = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_id_instr    <= 32'd0;
            r_id_pcp4     <= 32'd0;
            r_id_valid    <= 1'b0;
            r_fault_pc    <= 32'd0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state       <= w_nxt_state;
            r_pc          <= w_nxt_pc;
            r_id_instr    <= w_nxt_id_instr;
            r_id_pcp4     <= w_nxt_id_pcp4;
            r_id_valid    <= w_nxt_id_valid;
            r_fault_pc    <= w_nxt_fault_pc;
            r_fetch_count <= w_nxt_fetch_count;
        end
    end

    assign IM_Address     = r_pc;
    assign ID_Instruction = r_id_instr;
    assign ID_PCPlus4     = r_id_pcp4;
    assign ID_Valid       = r_id_valid;
    assign Fault          = (r_state == ST_FAULT);
    assign FaultPC        = r_fault_pc;
    assign FetchCount     = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal expectations,
// then randomized control inputs checked every cycle against a behavioural model.
module tb_instruction_fetch_unit;

    localparam int IW = 128;

    logic        Clk;
    logic        Rst;
    logic [31:0] IM_Address;
    logic [31:0] IM_Instruction;
    logic        Stall;
    logic        Flush;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] ID_Instruction;
    logic [31:0] ID_PCPlus4;
    logic        ID_Valid;
    logic        Fault;
    logic [31:0] FaultPC;
    logic [31:0] FetchCount;

    logic [31:0] mem [IW];

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Behavioural model of the architecturally visible state
    logic [31:0] m_pc, m_instr, m_pcp4, m_fault_pc, m_count;
    logic        m_valid, m_fault;

    instruction_fetch_unit #(.RESET_PC(32'h0), .INSTR_WORDS(IW)) dut (
        .Clk(Clk), .Rst(Rst), .IM_Address(IM_Address), .IM_Instruction(IM_Instruction),
        .Stall(Stall), .Flush(Flush), .Redirect(Redirect), .RedirectTarget(RedirectTarget),
        .ID_Instruction(ID_Instruction), .ID_PCPlus4(ID_PCPlus4), .ID_Valid(ID_Valid),
        .Fault(Fault), .FaultPC(FaultPC), .FetchCount(FetchCount)
    );

    assign IM_Instruction = (IM_Address < 32'(IW * 4)) ? mem[IM_Address[8:2]] : 32'hDEAD_BEEF;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bubble();
        m_instr = 32'd0;
        m_pcp4  = 32'd0;
        m_valid = 1'b0;
    endtask

    // Model: one architectural step per rising edge, from the rules of operation
    always @(posedge Clk) begin
        if (Rst) begin
            m_pc = 32'd0; m_fault = 0; m_fault_pc = 0; m_count = 0;
            bubble();
        end else if (m_fault) begin
            bubble();
        end else if (m_pc % 4 != 0 || m_pc >= IW * 4) begin
            m_fault = 1; m_fault_pc = m_pc;
            bubble();
        end else if (Redirect) begin
            m_pc = RedirectTarget;
            bubble();
        end else if (Stall) begin
            if (Flush) bubble();
        end else begin
            if (Flush) begin
                bubble();
            end else begin
                m_instr = mem[m_pc / 4];
                m_pcp4  = m_pc + 4;
                m_valid = 1;
                m_count = m_count + 1;
            end
            m_pc = m_pc + 4;
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("m.IM_Address", IM_Address, m_pc);
            chk("m.ID_Instruction", ID_Instruction, m_instr);
            chk("m.ID_PCPlus4", ID_PCPlus4, m_pcp4);
            chk("m.ID_Valid", 32'(ID_Valid), 32'(m_valid));
            chk("m.Fault", 32'(Fault), 32'(m_fault));
            chk("m.FaultPC", FaultPC, m_fault_pc);
            chk("m.FetchCount", FetchCount, m_count);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic clr_in();
        Stall = 0; Flush = 0; Redirect = 0; RedirectTarget = 0;
    endtask

    task automatic do_reset();
        clr_in();
        Rst = 1;
        step(2);
        Rst = 0;
    endtask

    initial begin
        Rst = 1;
        clr_in();
        for (int i = 0; i < IW; i++) mem[i] = 32'(i * 4);
        step(2);
        chk_en = 1;

        // Sequential fetch
        do_reset();
        chk("rst.IM_Address", IM_Address, 32'h0);
        chk("rst.ID_Valid", 32'(ID_Valid), 32'h0);
        chk("rst.FetchCount", FetchCount, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("seq.IM_Address", IM_Address, 32'(i * 4));
            chk("seq.ID_Instruction", ID_Instruction, 32'((i - 1) * 4));
            chk("seq.ID_PCPlus4", ID_PCPlus4, 32'(i * 4));
            chk("seq.ID_Valid", 32'(ID_Valid), 32'h1);
        end
        chk("seq.FetchCount", FetchCount, 32'd5);
        chk("seq.model_pc", m_pc, 32'd20);

        // Stall at PC=8
        do_reset();
        step(2);
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.IM_Address", IM_Address, 32'h8);
            chk("stall.ID_Instruction", ID_Instruction, 32'h4);
            chk("stall.FetchCount", FetchCount, 32'd2);
        end
        Stall = 0;
        step();
        chk("stall.release_instr", ID_Instruction, 32'h8);
        chk("stall.release_addr", IM_Address, 32'hC);

        // Redirect together with stall at PC=20
        do_reset();
        step(5);
        Redirect = 1; RedirectTarget = 32'h10; Stall = 1;
        step();
        clr_in();
        chk("redir.IM_Address", IM_Address, 32'h10);
        chk("redir.ID_Valid", 32'(ID_Valid), 32'h0);
        chk("redir.FetchCount", FetchCount, 32'd5);
        step();
        chk("redir.ID_Instruction", ID_Instruction, 32'h10);
        chk("redir.ID_PCPlus4", ID_PCPlus4, 32'h14);
        chk("redir.ID_Valid2", 32'(ID_Valid), 32'h1);

        // Flush only at PC=12
        do_reset();
        step(3);
        Flush = 1;
        step();
        Flush = 0;
        chk("flush.ID_Valid", 32'(ID_Valid), 32'h0);
        chk("flush.ID_Instruction", ID_Instruction, 32'h0);
        chk("flush.IM_Address", IM_Address, 32'h10);
        chk("flush.FetchCount", FetchCount, 32'd3);

        // Misaligned redirect fault
        do_reset();
        Redirect = 1; RedirectTarget = 32'h6;
        step();
        clr_in();
        chk("mis.IM_Address", IM_Address, 32'h6);
        chk("mis.Fault_pre", 32'(Fault), 32'h0);
        step();
        chk("mis.Fault", 32'(Fault), 32'h1);
        chk("mis.FaultPC", FaultPC, 32'h6);
        Redirect = 1; RedirectTarget = 32'h40; Stall = 1;
        step(2);
        clr_in();
        chk("mis.frozen_pc", IM_Address, 32'h6);
        chk("mis.Fault_hold", 32'(Fault), 32'h1);
        chk("mis.ID_Valid", 32'(ID_Valid), 32'h0);

        // Free run to end of memory
        do_reset();
        step(IW);
        chk("range.IM_Address", IM_Address, 32'h200);
        chk("range.Fault_pre", 32'(Fault), 32'h0);
        step();
        chk("range.Fault", 32'(Fault), 32'h1);
        chk("range.FaultPC", FaultPC, 32'h200);
        chk("range.FetchCount", FetchCount, 32'd128);
        Redirect = 1; RedirectTarget = 32'h0; Stall = 1;
        step(2);
        clr_in();
        chk("range.frozen_pc", IM_Address, 32'h200);
        chk("range.FetchCount_hold", FetchCount, 32'd128);
        chk("range.model_fault_pc", m_fault_pc, 32'h200);

        // Reset clears a sticky fault
        Rst = 1;
        step();
        Rst = 0;
        chk("rstf.Fault", 32'(Fault), 32'h0);
        chk("rstf.FaultPC", FaultPC, 32'h0);
        chk("rstf.IM_Address", IM_Address, 32'h0);

        // Reset mid-operation at PC=0x40
        step(16);
        chk("mid.IM_Address", IM_Address, 32'h40);
        chk("mid.ID_Valid", 32'(ID_Valid), 32'h1);
        Rst = 1;
        step();
        Rst = 0;
        chk("mid.rst_pc", IM_Address, 32'h0);
        chk("mid.rst_valid", 32'(ID_Valid), 32'h0);
        chk("mid.rst_instr", ID_Instruction, 32'h0);
        chk("mid.rst_pcp4", ID_PCPlus4, 32'h0);
        chk("mid.rst_count", FetchCount, 32'h0);

        // Randomized control inputs and memory contents
        for (int i = 0; i < IW; i++) mem[i] = $urandom;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            Rst      = ($urandom_range(0, 99) == 0);
            Stall    = ($urandom_range(0, 3) == 0);
            Flush    = ($urandom_range(0, 9) == 0);
            Redirect = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 19))
                0:       RedirectTarget = $urandom;
                1:       RedirectTarget = 32'($urandom_range(0, IW - 1) * 4 + $urandom_range(1, 3));
                default: RedirectTarget = 32'($urandom_range(0, IW - 1) * 4);
            endcase
            step();
        end
        clr_in();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front end of the MIPS pipeline and the initiator side of the instruction memory interface. Holds the program counter, drives the word-aligned fetch address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register. It handles hazard stalls, branch/jump redirects and flushes, and detects fetch faults. A 32-bit fetched-instruction counter is kept for performance checks.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- INSTR_WORDS, 128: words of instruction memory. Valid fetch addresses are 0 to INSTR_WORDS*4-4.

Ports:
- Clk  input  1  clock. All state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- IM_Address  output  32  fetch address. Equals PC (combinational).
- IM_Instruction  input  32  instruction word at IM_Address. Valid in the same cycle.
- Stall  input  1  hold PC and IF/ID contents (load-use hazard from ID).
- Flush  input  1  replace IF/ID contents with a bubble this cycle.
- Redirect  input  1  branch taken or jump resolved. Load PC from RedirectTarget.
- RedirectTarget  input  32  new PC when Redirect=1.
- ID_Instruction  output  32  registered instruction.
- ID_PCPlus4  output  32  registered address of that instruction plus 4.
- ID_Valid  output  1  ID_Instruction holds a real instruction, not a bubble.
- Fault  output  1  sticky fetch fault.
- FaultPC  output  32  address that caused the fault.
- FetchCount  output  32  number of valid instructions captured into IF/ID.

## Operation
- Reset (Rst=1 at an edge): PC=RESET_PC. ID_Instruction=0, ID_PCPlus4=0, ID_Valid=0, Fault=0, FaultPC=0, FetchCount=0. Rst overrides every other input.
- Priority per edge: Rst > Fault hold > Redirect > Stall > normal fetch. Flush is applied to IF/ID after PC selection.
- Normal fetch (no Stall, Redirect, Flush or Fault):
  - PC <= PC+4.
  - ID_Instruction <= IM_Instruction; ID_PCPlus4 <= PC+4; ID_Valid <= 1.
  - FetchCount increments.
- Stall=1, Redirect=0: PC and the IF/ID registers hold. FetchCount holds.
- Redirect=1 (ignores Stall):
  - PC <= RedirectTarget.
  - IF/ID becomes a bubble: ID_Instruction=0 (nop), ID_PCPlus4=0, ID_Valid=0. This squashes the wrong-path word.
  - FetchCount holds.
- Flush=1 without Redirect:
  - IF/ID becomes a bubble.
  - PC advances by 4 if Stall=0 and holds if Stall=1.
  - FetchCount holds.
- Fault detection is evaluated on the PC value about to be fetched:
  - PC[1:0]≠0, or PC ≥ INSTR_WORDS*4, sets Fault=1 and FaultPC=PC at that edge.
  - IF/ID captures a bubble at that edge.
  - A misaligned RedirectTarget is accepted into PC, then faults on the next edge.
- Fault state: PC, FaultPC and FetchCount freeze. IF/ID stays a bubble (ID_Valid=0). Stall, Flush and Redirect are ignored until Rst.
- Arithmetic: PC+4 is modulo 2^32. The range check faults before wrap is reachable whenever INSTR_WORDS*4 < 2^32. FetchCount wraps from 0xFFFF_FFFF to 0.
- IM_Address always equals PC, including during stall and fault. The memory is read-only and has no side effects.

## Timing
- Fetch latency is 1 cycle: the word at PC on IM_Address during cycle n appears on ID_Instruction after edge n, with ID_Valid=1.
- Redirect penalty:
  - Redirect in cycle n puts RedirectTarget on IM_Address in cycle n+1.
  - The target instruction appears in IF/ID after edge n+1.
  - Exactly one bubble is inserted.
- Stall held for k cycles freezes IF/ID for k cycles. On release, the next edge captures the word at the held PC.
- Fault asserts one edge after the faulting PC is loaded, so it is visible in the cycle after that PC appears on IM_Address.
- First valid instruction after Rst deasserts: ID_Valid=1 after the first non-reset edge, with ID_PCPlus4=RESET_PC+4.

## Test plan
- Sequential fetch: memory[i]=i*4. Release reset and run 5 cycles.
  - IM_Address = 0,4,8,12,16.
  - ID_Instruction = 0,4,8,12 with ID_Valid=1 and ID_PCPlus4 = 4,8,12,16.
  - FetchCount=5.
- Stall: assert Stall for 3 cycles while PC=8.
  - IM_Address stays 8 and ID_Instruction stays 4.
  - FetchCount holds.
  - On release, ID_Instruction=8 at the next edge.
- Redirect during stall: at PC=20, assert Redirect=1, RedirectTarget=0x10 and Stall=1 together.
  - Next cycle: IM_Address=0x10, ID_Valid=0.
  - One cycle later: ID_Instruction=0x10, ID_PCPlus4=0x14.
- Flush only: at PC=12, assert Flush.
  - ID_Valid=0, ID_Instruction=0, PC=16.
  - FetchCount unchanged.
- Faults (Rst between cases):
  - Redirect to 0x6: Fault=1, FaultPC=0x6, PC frozen.
  - Free-run to 0x200 with INSTR_WORDS=128: Fault=1, FaultPC=0x200.
  - In both cases, later Redirect and Stall inputs are ignored.
- Reset mid-operation: assert Rst at PC=0x40 with ID_Valid=1.
  - Next edge: PC=RESET_PC and all outputs return to their reset values.
  - A sticky Fault clears.
